// File: rtl/iru_rot_engine.sv
// iru_rot_engine: buffers one DIM x DIM pixel window, then streams the window
// rotated about its centre (Q2.FRAC cos/sin back-mapping) in raster order with
// valid/ready handshaking. Sources outside the window are replaced by FILL.
// Optional build macro IRU_ROT_ROUND_EN: when defined the Q2.FRAC products
// round half-up before the shift; otherwise they truncate toward -inf.
module iru_rot_engine #(
  parameter int DIM   = 20,
  parameter int PIX_W = 8,
  parameter int FRAC  = 30,
  parameter int FILL  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [31:0]             cos_in,
  input  logic [31:0]             sin_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        in_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIX_W-1:0]        out_pixel,
  output logic [$clog2(DIM)-1:0]  out_row,
  output logic [$clog2(DIM)-1:0]  out_col,
  output logic                    out_last,
  output logic                    busy
);

  localparam int AW   = $clog2(DIM);
  localparam int SW   = AW + 2;
  localparam int PW   = 32 + SW;
  localparam int NPIX = DIM * DIM;
  localparam int MW   = $clog2(NPIX);

  localparam logic signed [SW-1:0] HALF_SW = SW'(DIM / 2);
  localparam logic signed [PW-1:0] HALF_PW = PW'(DIM / 2);
  localparam logic signed [PW-1:0] DIM_PW  = PW'(DIM);
`ifdef IRU_ROT_ROUND_EN
  localparam logic signed [PW-1:0] RND_PW  = PW'(1) <<< (FRAC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ROT  = 2'd2
  } state_t;

  // Drops the FRAC fraction bits of a full-width product.
  function automatic logic signed [PW-1:0] scale_q(input logic signed [PW-1:0] p);
`ifdef IRU_ROT_ROUND_EN
    scale_q = (p + RND_PW) >>> FRAC;
`else
    scale_q = p >>> FRAC;
`endif
  endfunction

  state_t                   state_q, state_d;
  logic signed [31:0]       cos_q, cos_d;
  logic signed [31:0]       sin_q, sin_d;
  logic [MW-1:0]            laddr_q, laddr_d;
  logic [AW-1:0]            r_q, r_d;
  logic [AW-1:0]            c_q, c_d;
  logic                     done_q, done_d;
  logic                     out_valid_q, out_valid_d;
  logic [PIX_W-1:0]         out_pixel_q, out_pixel_d;
  logic [AW-1:0]            out_row_q, out_row_d;
  logic [AW-1:0]            out_col_q, out_col_d;
  logic                     out_last_q, out_last_d;

  logic [PIX_W-1:0]         pix_mem [NPIX];
  logic                     mem_we;

  logic signed [SW-1:0]     rs, cs;
  logic signed [PW-1:0]     rs_x, cs_x, cos_x, sin_x;
  logic signed [PW-1:0]     rc, rsn, cc, csn;
  logic signed [PW-1:0]     src_row, src_col;
  logic                     in_range;
  logic [MW-1:0]            rd_addr;
  logic [PIX_W-1:0]         rot_pixel;

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

  // Back-map the current destination (r, c) to a source pixel of the window.
  always_comb begin
    rs      = $signed({2'b00, r_q}) - HALF_SW;
    cs      = $signed({2'b00, c_q}) - HALF_SW;
    rs_x    = {{(PW-SW){rs[SW-1]}}, rs};
    cs_x    = {{(PW-SW){cs[SW-1]}}, cs};
    cos_x   = {{SW{cos_q[31]}}, cos_q};
    sin_x   = {{SW{sin_q[31]}}, sin_q};
    rc      = scale_q(rs_x * cos_x);
    rsn     = scale_q(rs_x * sin_x);
    cc      = scale_q(cs_x * cos_x);
    csn     = scale_q(cs_x * sin_x);
    src_col = cc - rsn + HALF_PW;
    src_row = csn + rc + HALF_PW;
    in_range = !src_row[PW-1] && (src_row < DIM_PW) &&
               !src_col[PW-1] && (src_col < DIM_PW);
    rd_addr  = MW'(src_row[AW-1:0]) * MW'(DIM) + MW'(src_col[AW-1:0]);
    rot_pixel = PIX_W'(FILL);
    if (in_range) rot_pixel = pix_mem[rd_addr];
  end

  // Next-state, counters and output-register update.
  always_comb begin
    state_d     = state_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    laddr_d     = laddr_q;
    r_d         = r_q;
    c_d         = c_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cos_d   = cos_in;
          sin_d   = sin_in;
          laddr_d = '0;
          r_d     = '0;
          c_d     = '0;
          done_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          mem_we  = 1'b1;
          laddr_d = laddr_q + MW'(1);
          if (laddr_q == MW'(NPIX - 1)) begin
            laddr_d = '0;
            state_d = S_ROT;
          end
        end
      end
      S_ROT: begin
        if (!out_valid_q || out_ready) begin
          if (!done_q) begin
            out_valid_d = 1'b1;
            out_pixel_d = rot_pixel;
            out_row_d   = r_q;
            out_col_d   = c_q;
            out_last_d  = (r_q == AW'(DIM - 1)) && (c_q == AW'(DIM - 1));
            if (out_last_d) begin
              done_d = 1'b1;
            end else if (c_q == AW'(DIM - 1)) begin
              c_d = '0;
              r_d = r_q + AW'(1);
            end else begin
              c_d = c_q + AW'(1);
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cos_q       <= '0;
      sin_q       <= '0;
      laddr_q     <= '0;
      r_q         <= '0;
      c_q         <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      laddr_q     <= laddr_d;
      r_q         <= r_d;
      c_q         <= c_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
    end
  end

  // Window buffer; every job rewrites all of it before reading, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) pix_mem[laddr_q] <= in_pixel;
  end

endmodule

// File: tb/tb_iru_rot_engine.sv
// Directed bench for iru_rot_engine (DIM=20, PIX_W=8): identity, 90, 45 and
// 180 degree jobs, backpressure with ignored start pulses, reset mid-rotate,
// back-to-back jobs.
module tb_iru_rot_engine;
  localparam int DIM = 20;
  localparam int N   = DIM * DIM;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cos_in = '0;
  logic [31:0] sin_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pixel;
  logic [4:0]  out_row;
  logic [4:0]  out_col;
  logic        out_last;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] frm [N];
  logic [7:0] got [N];

  iru_rot_engine #(.DIM(DIM), .PIX_W(8), .FRAC(30), .FILL(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cos_in(cos_in), .sin_in(sin_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic fill_frame(input int seed);
    for (int i = 0; i < N; i++)
      frm[i] = (seed == 0) ? 8'(i) : 8'(i * 7 + 13);
  endtask

  // mode 0 identity, 1 = 90 deg, 2 = 180 deg (hand-derived source maps)
  function automatic logic [7:0] model(input int mode, input int r, input int c);
    int sr, sc;
    sr = r; sc = c;
    if (mode == 1) begin sr = c; sc = DIM - r; end
    if (mode == 2) begin sr = DIM - r; sc = DIM - c; end
    if (sr < 0 || sr >= DIM || sc < 0 || sc >= DIM) return 8'd0;
    return frm[sr * DIM + sc];
  endfunction

  // Called at a negedge; returns at a negedge with the job in LOAD.
  task automatic start_job(input logic [31:0] cv, input logic [31:0] sv);
    cos_in = cv; sin_in = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cos_in = 32'h1234_5678; sin_in = 32'h0bad_cafe;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("in_ready_load", in_ready, 1);
  endtask

  task automatic load(input bit gaps, input bit poke);
    int i, cyc;
    bit acc;
    i = 0; cyc = 0;
    while (i < N && cyc < 5000) begin
      @(negedge clk); cyc++;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_pixel = frm[i];
      if (poke) begin
        start = ($urandom_range(0, 9) == 0);
        cos_in = $urandom; sin_in = $urandom;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
    end
    if (i < N) chk("load_timeout", i, N);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    chk("in_ready_after_load", in_ready, 0);
    chk("out_valid_rot_entry", out_valid, 0);
  endtask

  task automatic collect(input int mode, input bit rnd, input bit poke,
                         input int stop_at, input bit last_start);
    int beat, cyc;
    bit stall;
    logic [7:0] s_pix;
    logic [4:0] s_row, s_col;
    logic s_last;
    beat = 0; cyc = 0; stall = 0;
    s_pix = '0; s_row = '0; s_col = '0; s_last = 1'b0;
    while (beat < stop_at && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_pixel", out_pixel, s_pix);
        chk("stall_row", out_row, s_row);
        chk("stall_col", out_col, s_col);
        chk("stall_last", out_last, s_last);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      if (poke) begin
        start = ($urandom_range(0, 7) == 0);
        cos_in = $urandom; sin_in = $urandom;
      end
      if (out_valid && out_ready) begin
        chk("out_row", out_row, beat / DIM);
        chk("out_col", out_col, beat % DIM);
        chk("out_last", out_last, (beat == N - 1));
        if (mode < 3) chk("out_pixel", out_pixel, model(mode, beat / DIM, beat % DIM));
        got[beat] = out_pixel;
        if (last_start && beat == N - 1) begin
          start = 1'b1; cos_in = 32'h0; sin_in = 32'h0;
        end
        beat++;
      end
      stall = out_valid && !out_ready;
      s_pix = out_pixel; s_row = out_row; s_col = out_col; s_last = out_last;
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    if (beat < stop_at) chk("rot_timeout", beat, stop_at);
    if (!rnd && stop_at == N) chk("rot_cycles", cyc, N);
  endtask

  // After the final handshake: engine must be idle with nothing pending.
  task automatic post_job();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity, final-beat start pulse must be ignored
    fill_frame(0);
    start_job(32'h4000_0000, 32'h0);
    load(0, 0);
    collect(0, 0, 0, N, 1);
    post_job();

    // 90 degrees
    start_job(32'h0, 32'h4000_0000);
    load(0, 0);
    collect(1, 0, 0, N, 0);
    chk("rot90_1_3", got[1 * DIM + 3], 79);
    post_job();

    // 45 degrees, pixel (10,0)
    start_job(32'h2D41_3CCD, 32'h2D41_3CCD);
    load(0, 0);
    collect(3, 0, 0, N, 0);
`ifdef IRU_ROT_ROUND_EN
    chk("rot45_10_0", got[10 * DIM + 0], 63);
`else
    chk("rot45_10_0", got[10 * DIM + 0], 42);
`endif
    post_job();

    // backpressure, input gaps and ignored start pulses
    start_job(32'h4000_0000, 32'h0);
    load(1, 1);
    collect(0, 1, 1, N, 0);
    post_job();

    // reset mid-rotate
    start_job(32'h4000_0000, 32'h0);
    load(0, 0);
    collect(0, 0, 0, 150, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_pixel", out_pixel, 0);
    chk("mid_rst_out_row", out_row, 0);
    chk("mid_rst_out_col", out_col, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // clean job after reset on a new frame, then back-to-back 180 degrees
    fill_frame(1);
    start_job(32'h4000_0000, 32'h0);
    load(0, 0);
    collect(0, 0, 0, N, 1);
    post_job();
    fill_frame(0);
    start_job(32'hC000_0000, 32'h0);
    load(0, 0);
    collect(2, 0, 0, N, 0);
    post_job();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
